// File: rtl/sync_rst_preset_seq_pkg.sv
// Shared types and default timing for the sync reset/preset sequencer.
package sync_seq_pkg;

    typedef enum logic [1:0] {
        SEQ_RST  = 2'd0,
        SEQ_PRE  = 2'd1,
        SEQ_DONE = 2'd2,
        SEQ_IDLE = 2'd3
    } seq_state_t;

    localparam int unsigned RST_CYCLES_DEF = 4;
    localparam int unsigned PRE_CYCLES_DEF = 2;
    localparam int unsigned CNT_W_DEF      = 8;

endpackage

// File: rtl/sync_rst_preset_seq_if.sv
// Request/status bundle between an initiator and the reset/preset sequencer.
interface sync_rst_preset_seq_if;

    logic req_i;
    logic preset_en;
    logic rst_o;
    logic preset_o;
    logic busy_o;
    logic done_o;

    modport master (
        output req_i,
        output preset_en,
        input  rst_o,
        input  preset_o,
        input  busy_o,
        input  done_o
    );

    modport slave (
        input  req_i,
        input  preset_en,
        output rst_o,
        output preset_o,
        output busy_o,
        output done_o
    );

endinterface

// File: rtl/sync_rst_preset_seq_phase_cnt.sv
// Loadable phase down-counter; o_zero_c flags that this decrement reaches zero,
// i.e. the current cycle is the last one of the phase.
module seq_phase_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_dec;

    assign w_cnt_dec = r_cnt - CNT_W'(1);
    assign o_zero_c  = (w_cnt_dec == '0);

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= w_cnt_dec;
        end
    end

endmodule

// File: rtl/sync_rst_preset_seq.sv
// Timed reset then optional preset pulse generator for sync-reset/preset flops.
// Define SEQ_PENDING_EN to queue a request that arrives mid-sequence.
module sync_rst_preset_seq
    import sync_seq_pkg::*;
#(
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
    parameter int unsigned PRE_CYCLES = PRE_CYCLES_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    sync_rst_preset_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRE_CYCLES);

    if (RST_CYCLES < 1 || RST_CYCLES > (2**CNT_W) - 1) begin : g_bad_rst_cycles
        $error("RST_CYCLES must be in [1, 2**CNT_W-1]");
    end
    if (PRE_CYCLES < 1 || PRE_CYCLES > (2**CNT_W) - 1) begin : g_bad_pre_cycles
        $error("PRE_CYCLES must be in [1, 2**CNT_W-1]");
    end

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic             r_pre_sel;
    logic             w_pre_sel_next;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_cnt_val;
    logic             r_rst_o;
    logic             r_preset_o;
    logic             r_busy_o;
    logic             r_done_o;
`ifdef SEQ_PENDING_EN
    logic             r_pend;
    logic             r_pend_sel;
    logic             w_pend_next;
    logic             w_pend_sel_next;
`endif

    seq_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk        (clk),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero_c   (w_cnt_zero)
    );

    // Next state, counter control and preset selection; reset overrides everything.
    always_comb begin
        w_state_next   = r_state;
        w_pre_sel_next = r_pre_sel;
        w_cnt_load     = 1'b0;
        w_cnt_dec      = 1'b0;
        w_cnt_val      = RST_LOAD;
`ifdef SEQ_PENDING_EN
        w_pend_next     = r_pend;
        w_pend_sel_next = r_pend_sel;
`endif
        case (r_state)
            SEQ_RST, SEQ_PRE: begin
`ifdef SEQ_PENDING_EN
                if (bus.req_i) begin
                    w_pend_next     = 1'b1;
                    w_pend_sel_next = bus.preset_en;
                end
`endif
                if (!w_cnt_zero) begin
                    w_cnt_dec = 1'b1;
                end else if (r_state == SEQ_RST && r_pre_sel) begin
                    w_state_next = SEQ_PRE;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = PRE_LOAD;
                end else begin
                    w_state_next = SEQ_DONE;
                end
            end
            SEQ_DONE, SEQ_IDLE: begin
                w_state_next = SEQ_IDLE;
                if (bus.req_i) begin
                    w_state_next   = SEQ_RST;
                    w_cnt_load     = 1'b1;
                    w_pre_sel_next = bus.preset_en;
                end
`ifdef SEQ_PENDING_EN
                else if (r_state == SEQ_DONE && r_pend) begin
                    w_state_next   = SEQ_RST;
                    w_cnt_load     = 1'b1;
                    w_pre_sel_next = r_pend_sel;
                end
                w_pend_next = 1'b0;
`endif
            end
            default: begin
                w_state_next = SEQ_RST;
                w_cnt_load   = 1'b1;
            end
        endcase

        if (reset) begin
            w_state_next   = SEQ_RST;
            w_cnt_load     = 1'b1;
            w_cnt_val      = RST_LOAD;
            w_pre_sel_next = bus.preset_en;
`ifdef SEQ_PENDING_EN
            w_pend_next    = 1'b0;
`endif
        end
    end

    // Outputs are decoded from the next state so they flop alongside it.
    always_ff @(posedge clk) begin
        r_state    <= w_state_next;
        r_pre_sel  <= w_pre_sel_next;
        r_rst_o    <= (w_state_next == SEQ_RST);
        r_preset_o <= (w_state_next == SEQ_PRE);
        r_busy_o   <= (w_state_next == SEQ_RST) || (w_state_next == SEQ_PRE);
        r_done_o   <= (w_state_next == SEQ_DONE);
`ifdef SEQ_PENDING_EN
        r_pend     <= w_pend_next;
        r_pend_sel <= w_pend_sel_next;
`endif
    end

    assign bus.rst_o    = r_rst_o;
    assign bus.preset_o = r_preset_o;
    assign bus.busy_o   = r_busy_o;
    assign bus.done_o   = r_done_o;

endmodule
